seq_frame_detector: RTL
=======================

Name: seq_frame_detector

Overview:
Parametrised successor of the team's fixed-pattern serial sequence detector. Hunts a serial stream for a configurable PAT_LEN-bit start pattern, with overlap handled by a shift-register compare. On a match it passes the next PAYLOAD_LEN bits through as valid payload, then re-arms. Counts completed frames. Sits between the serial input stage and the deserialiser in the lab datapath.

Parameters:
PAT_LEN, 6, start-pattern length in bits (>=2)
PATTERN, 6'b110101, start pattern; MSB is the first bit received
PAYLOAD_LEN, 10, payload bits forwarded per frame (>=1)
CNT_W, 4, countOut width; must satisfy 2^CNT_W >= PAYLOAD_LEN
FCNT_W, 8, frameCount width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
serIn  in  1  serial data in, sampled on clk edges where clkEn=1
clkEn  in  1  bit-rate enable; state, history and counters advance only when high
serOut  out  1  combinational copy of serIn
serOutValid  out  1  high while in PAYLOAD state (decoded from state only)
countOut  out  CNT_W  payload bit index, 0..PAYLOAD_LEN-1
frameDone  out  1  one-clk pulse after the last payload bit
frameCount  out  FCNT_W  completed frames, saturating

Behaviour:
- Reset is asynchronous and active-high. It applies immediately, including mid-frame. Reset values: state=HUNT, history=0, histCnt=0, countOut=0, frameDone=0, frameCount=0, so serOutValid=0.
- History: PAT_LEN-bit shift register. On a clkEn edge in HUNT: hist <= {hist[PAT_LEN-2:0], serIn}. histCnt saturates at PAT_LEN.
- Match condition: clkEn=1, state=HUNT, {hist[PAT_LEN-2:0], serIn}==PATTERN, and histCnt>=PAT_LEN-1.
  - The histCnt qualifier means reset zeros never count as received bits (e.g. PATTERN=0000 needs four real bits).
  - A match may overlap a failed partial match. Example: 1110101 matches on its 7th bit.
- HUNT -> PAYLOAD on a match edge. On that same edge: countOut <= 0, hist <= 0, histCnt <= 0.
- PAYLOAD:
  - serOutValid=1. The first payload bit is serIn in the clkEn window after the edge that completed the pattern.
  - Each clkEn edge: countOut <= countOut+1.
  - On a clkEn edge with countOut==PAYLOAD_LEN-1: state <= HUNT, countOut <= 0, frameDone <= 1.
  - Pattern bits inside the payload are ignored, and the history is not shifted.
- Payload length is exactly PAYLOAD_LEN clkEn edges. serOutValid may stay high across extra clk cycles while clkEn=0.
- clkEn=0: state, hist, histCnt and countOut all hold. serOut still follows serIn.
- frameDone:
  - Registered. High for exactly one clk cycle after the terminating edge.
  - Cleared on the next clk edge regardless of clkEn.
- frameCount: +1 on the terminating edge; holds at all-ones when saturated.
- Re-arm: after PAYLOAD the full PAT_LEN bits must arrive again. The terminating edge's bit is payload, not history.
- State encoding: two states (HUNT, PAYLOAD). Any illegal encoding -> HUNT on the next clk edge.

Test Plan:
1. Defaults, clkEn=1. rst, then serIn=110101 followed by 1010011100.
   -> serOutValid rises the cycle after the 6th pattern bit and stays high 10 cycles.
   -> countOut steps 0..9; serOut equals the payload bits.
   -> frameDone pulses once; frameCount=1.
2. Overlap: serIn=1110101 then 10 payload bits.
   -> match on the 7th bit; one frame.
   -> Also serIn=11011010 1: no match until the trailing 110101 completes.
3. clkEn gating: clkEn=1 every 4th clk; drop clkEn for 3 enables at countOut=5.
   -> state, countOut and serOutValid hold.
   -> frame still ends after 10 enabled edges; frameDone is 1 clk wide.
4. Payload contains 110101 at bits 2..7.
   -> no re-trigger.
   -> After the frame, 10101 alone gives no match; a full 110101 is required for frame 2 (frameCount=2).
5. Reset mid-payload at countOut=4.
   -> on rst rise: serOutValid=0, countOut=0, frameCount=0, frameDone=0.
   -> after release, the next match starts cleanly.
6. Param sweep: PATTERN=4'b0000, PAT_LEN=4, PAYLOAD_LEN=3, FCNT_W=2.
   -> no match from reset zeros until 4 real 0 bits.
   -> after 5 frames, frameCount=3 (saturated).

Source files
------------

// File: rtl/seq_frame_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_detector_if
// Purpose  : Bundles the serial stream, bit-rate enable and the detector's
//            payload/frame status outputs.
// Ports    : serIn, clkEn                 - serial bit and bit-rate enable
//            serOut, serOutValid, countOut - forwarded payload bit and index
//            frameDone, frameCount         - frame completion pulse / count
// Modports : master - drives the stream, observes status (upstream / bench)
//            slave  - the detector itself
// Revision : 1.0 - initial release
// ============================================================================
interface seq_frame_detector_if #(
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 8
);
    logic              serIn;
    logic              clkEn;
    logic              serOut;
    logic              serOutValid;
    logic [CNT_W-1:0]  countOut;
    logic              frameDone;
    logic [FCNT_W-1:0] frameCount;

    modport master (
        output serIn, clkEn,
        input  serOut, serOutValid, countOut, frameDone, frameCount
    );

    modport slave (
        input  serIn, clkEn,
        output serOut, serOutValid, countOut, frameDone, frameCount
    );
endinterface
`default_nettype wire

// File: rtl/seq_frame_detector.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_detector
// Purpose  : Hunts a serial stream for a PAT_LEN-bit start pattern (MSB first,
//            overlapping matches allowed), then forwards the next PAYLOAD_LEN
//            enabled bits as valid payload and re-arms. Counts frames.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-high reset
//            bus - slave side of seq_frame_detector_if (stream in, payload
//                  bit/valid/index out, frame done pulse, saturating count)
// Revision : 1.0 - initial release
// ============================================================================
module seq_frame_detector #(
    parameter int                 PAT_LEN     = 6,
    parameter logic [PAT_LEN-1:0] PATTERN     = 6'b110101,
    parameter int                 PAYLOAD_LEN = 10,
    parameter int                 CNT_W       = 4,
    parameter int                 FCNT_W      = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    seq_frame_detector_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    localparam int                c_hc_w       = $clog2(PAT_LEN + 1);
    localparam logic [c_hc_w-1:0] c_hist_full  = c_hc_w'(PAT_LEN);
    localparam logic [c_hc_w-1:0] c_hist_match = c_hc_w'(PAT_LEN - 1);
    localparam logic [c_hc_w-1:0] c_hc_one     = c_hc_w'(1);
    localparam logic [CNT_W-1:0]  c_cnt_last   = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one    = CNT_W'(1);
    localparam logic [FCNT_W-1:0] c_fcnt_one   = FCNT_W'(1);

    state_t              r_state_q,       w_state_d;
    // Only the newest PAT_LEN-1 received bits need to be kept: the window
    // compared against PATTERN is these bits plus the bit arriving now.
    logic [PAT_LEN-2:0]  r_hist_q,        w_hist_d;
    logic [c_hc_w-1:0]   r_hist_cnt_q,    w_hist_cnt_d;
    logic [CNT_W-1:0]    r_count_q,       w_count_d;
    logic                r_frame_done_q,  w_frame_done_d;
    logic [FCNT_W-1:0]   r_frame_count_q, w_frame_count_d;

    logic [PAT_LEN-1:0]  w_window;
    logic                w_match;

    assign w_window = {r_hist_q, bus.serIn};

    // histCnt qualifier keeps reset-cleared history from posing as real bits.
    assign w_match  = bus.clkEn
                   && (r_state_q == ST_HUNT)
                   && (w_window == PATTERN)
                   && (r_hist_cnt_q >= c_hist_match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q       <= ST_HUNT;
            r_hist_q        <= '0;
            r_hist_cnt_q    <= '0;
            r_count_q       <= '0;
            r_frame_done_q  <= 1'b0;
            r_frame_count_q <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_hist_q        <= w_hist_d;
            r_hist_cnt_q    <= w_hist_cnt_d;
            r_count_q       <= w_count_d;
            r_frame_done_q  <= w_frame_done_d;
            r_frame_count_q <= w_frame_count_d;
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_hist_d        = r_hist_q;
        w_hist_cnt_d    = r_hist_cnt_q;
        w_count_d       = r_count_q;
        w_frame_done_d  = 1'b0;      // single-cycle pulse, cleared every clk
        w_frame_count_d = r_frame_count_q;

        case (r_state_q)
            ST_HUNT: begin
                if (bus.clkEn) begin
                    if (w_match) begin
                        // History is flushed so re-arming needs a full pattern.
                        w_state_d    = ST_PAYLOAD;
                        w_count_d    = '0;
                        w_hist_d     = '0;
                        w_hist_cnt_d = '0;
                    end else begin
                        w_hist_d = w_window[PAT_LEN-2:0];
                        if (r_hist_cnt_q != c_hist_full) begin
                            w_hist_cnt_d = r_hist_cnt_q + c_hc_one;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                if (bus.clkEn) begin
                    if (r_count_q == c_cnt_last) begin
                        w_state_d      = ST_HUNT;
                        w_count_d      = '0;
                        w_frame_done_d = 1'b1;
                        if (r_frame_count_q != {FCNT_W{1'b1}}) begin
                            w_frame_count_d = r_frame_count_q + c_fcnt_one;
                        end
                    end else begin
                        w_count_d = r_count_q + c_cnt_one;
                    end
                end
            end

            default: begin
                w_state_d    = ST_HUNT;
                w_count_d    = '0;
                w_hist_d     = '0;
                w_hist_cnt_d = '0;
            end
        endcase
    end

    assign bus.serOut      = bus.serIn;
    assign bus.serOutValid = (r_state_q == ST_PAYLOAD);
    assign bus.countOut    = r_count_q;
    assign bus.frameDone   = r_frame_done_q;
    assign bus.frameCount  = r_frame_count_q;

endmodule
`default_nettype wire
